// File: rtl/dram_model_if.sv
// Command/data bus of the behavioural DRAM model.
// The controller drives the master side and the memory implements the slave side.
interface dram_model_if #(parameter int A_W = 11);
  logic           CSn;
  logic           RASn;
  logic           CASn;
  logic [3:0]     WEn;
  logic [A_W-1:0] A;
  logic [31:0]    D;
  logic [31:0]    Q;
  logic           VALID;

  modport master (output CSn, RASn, CASn, WEn, A, D, input Q, VALID);
  modport slave  (input CSn, RASn, CASn, WEn, A, D, output Q, VALID);
endinterface

// File: rtl/dram_model.sv
// Single-bank DRAM model: ACT/PRE row control, TRCD gating, byte-masked writes
// and CL-deep pipelined reads into four byte-wide storage arrays.
module dram_model #(
  parameter int ROW_W = 11,
  parameter int COL_W = 10,
  parameter int CL    = 5,
  parameter int TRCD  = 5
) (
  input logic         CK,
  input logic         RST,
  dram_model_if.slave bus
);

  localparam int AW    = ROW_W + COL_W;
  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = $clog2(TRCD + 2);
  localparam logic [CNT_W-1:0] TRCD_CNT = CNT_W'(TRCD);

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_t;

  logic [7:0] Memory_byte0 [DEPTH];
  logic [7:0] Memory_byte1 [DEPTH];
  logic [7:0] Memory_byte2 [DEPTH];
  logic [7:0] Memory_byte3 [DEPTH];

  bank_state_t      state_q, state_d;
  logic [ROW_W-1:0] row_q;
  logic [CNT_W-1:0] trcd_cnt;
  logic [CL-1:0]    pipe_v;
  logic [31:0]      pipe_d [CL];

  logic          cmd_act, cmd_pre, cmd_rd, cmd_wr;
  logic          act_accept, col_ok, do_rd, do_wr;
  logic [AW-1:0] word_addr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cmd_act = 1'b0;
    cmd_pre = 1'b0;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    if (!bus.CSn) begin
      if (!bus.RASn && bus.CASn) begin
        if (bus.WEn == 4'hF)      cmd_act = 1'b1;
        else if (bus.WEn == 4'h0) cmd_pre = 1'b1;
      end else if (bus.RASn && !bus.CASn) begin
        if (bus.WEn == 4'hF) cmd_rd = 1'b1;
        else                 cmd_wr = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BANK_IDLE:   if (cmd_act) state_d = BANK_ACTIVE;
      BANK_ACTIVE: if (cmd_pre) state_d = BANK_IDLE;
      default:     state_d = BANK_IDLE;
    endcase
  end

  // ACT while a row is already open is dropped; the counter counts the ACT edge
  // itself, so a column command at ACT+TRCD sees trcd_cnt == TRCD.
  assign act_accept = (state_q == BANK_IDLE) && cmd_act;
  assign col_ok     = (state_q == BANK_ACTIVE) && (trcd_cnt >= TRCD_CNT);
  assign do_rd      = cmd_rd && col_ok;
  assign do_wr      = cmd_wr && col_ok;
  assign word_addr  = {row_q, bus.A[COL_W-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q   <= BANK_IDLE;
      row_q     <= '0;
      trcd_cnt  <= '0;
      pipe_v    <= '0;
      bus.Q     <= '0;
      bus.VALID <= 1'b0;
    end else begin
      state_q <= state_d;
      if (act_accept) begin
        row_q    <= bus.A[ROW_W-1:0];
        trcd_cnt <= CNT_W'(1);
      end else if (trcd_cnt < TRCD_CNT) begin
        trcd_cnt <= trcd_cnt + 1'b1;
      end
      pipe_v[0] <= do_rd;
      for (int i = 1; i < CL; i++) pipe_v[i] <= pipe_v[i-1];
      bus.VALID <= pipe_v[CL-1];
      if (pipe_v[CL-1]) bus.Q <= pipe_d[CL-1];
    end
  end

  // NOTE: storage and the read data pipe carry no reset; preloaded contents must
  // survive RST, and pipe_v alone decides whether pipe data is ever used.
  always_ff @(posedge CK) begin
    pipe_d[0] <= {Memory_byte3[word_addr], Memory_byte2[word_addr],
                  Memory_byte1[word_addr], Memory_byte0[word_addr]};
    for (int i = 1; i < CL; i++) pipe_d[i] <= pipe_d[i-1];
    if (do_wr) begin
      if (!bus.WEn[0]) Memory_byte0[word_addr] <= bus.D[7:0];
      if (!bus.WEn[1]) Memory_byte1[word_addr] <= bus.D[15:8];
      if (!bus.WEn[2]) Memory_byte2[word_addr] <= bus.D[23:16];
      if (!bus.WEn[3]) Memory_byte3[word_addr] <= bus.D[31:24];
    end
  end

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: the driver queues expected read words with their
// due cycle, and a negedge monitor checks every VALID against that queue.
module tb_dram_model;
  localparam int ROW_W = 11;
  localparam int COL_W = 10;
  localparam int CL    = 5;
  localparam int TRCD  = 5;

  logic CK  = 1'b0;
  logic RST = 1'b0;

  dram_model_if bus ();

  dram_model #(.ROW_W(ROW_W), .COL_W(COL_W), .CL(CL), .TRCD(TRCD)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_err  = 0;
  int          cyc    = 0;
  logic [31:0] last_q = '0;

  always @(posedge CK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: VALID must match the queue head exactly at its due cycle; otherwise Q holds.
  initial begin
    exp_t e;
    forever begin
      @(negedge CK);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        fail("missing_valid", 32'(cyc), 32'(e.due));
      end
      if (bus.VALID === 1'b1) begin
        if (sb.size() == 0) begin
          fail("unexpected_valid", bus.Q, last_q);
        end else begin
          e = sb.pop_front();
          check("read_latency", 32'(cyc), 32'(e.due));
          check("read_data", bus.Q, e.data);
          last_q = e.data;
        end
      end else begin
        check("q_hold", bus.Q, last_q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    @(negedge CK);
    bus.CSn  = csn;
    bus.RASn = rasn;
    bus.CASn = casn;
    bus.WEn  = wen;
    bus.A    = a;
    bus.D    = d;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
  endtask

  task automatic act(input logic [10:0] row);
    drive(1'b0, 1'b0, 1'b1, 4'hF, row, 32'h0);
  endtask

  task automatic pre();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
  endtask

  task automatic rd(input logic [10:0] col, input logic [31:0] exp);
    exp_t e;
    drive(1'b0, 1'b1, 1'b0, 4'hF, col, 32'h0);
    e.data = exp;
    e.due  = cyc + 1 + CL;
    sb.push_back(e);
  endtask

  task automatic rd_ignored(input logic [10:0] col);
    drive(1'b0, 1'b1, 1'b0, 4'hF, col, 32'h0);
  endtask

  task automatic wr(input logic [10:0] col, input logic [3:0] wen, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, wen, col, d);
  endtask

  task automatic preload(input logic [10:0] row, input logic [9:0] col, input logic [31:0] w);
    logic [20:0] a;
    a = {row, col};
    dut.Memory_byte0[a] = w[7:0];
    dut.Memory_byte1[a] = w[15:8];
    dut.Memory_byte2[a] = w[23:16];
    dut.Memory_byte3[a] = w[31:24];
  endtask

  function automatic logic [31:0] peek(input logic [10:0] row, input logic [9:0] col);
    logic [20:0] a;
    a = {row, col};
    return {dut.Memory_byte3[a], dut.Memory_byte2[a], dut.Memory_byte1[a], dut.Memory_byte0[a]};
  endfunction

  initial begin
    bus.CSn  = 1'b1;
    bus.RASn = 1'b1;
    bus.CASn = 1'b1;
    bus.WEn  = 4'hF;
    bus.A    = '0;
    bus.D    = '0;

    // Row 0x100, col 0 is word 0x40000.
    preload(11'h100, 10'd0, 32'h1234_5678);
    preload(11'h100, 10'd1, 32'hA5A5_0001);
    preload(11'h100, 10'd2, 32'hDEAD_BEEF);
    preload(11'h100, 10'd3, 32'h1122_3344);
    preload(11'h100, 10'd4, 32'h0BAD_F00D);
    preload(11'h100, 10'd5, 32'h5555_5555);
    preload(11'h200, 10'd1, 32'h9999_0000);

    #2 RST = 1'b1;
    repeat (3) @(negedge CK);
    check("reset_q", bus.Q, 32'h0);
    check("reset_valid", {31'b0, bus.VALID}, 32'h0);
    check("preload_kept", peek(11'h100, 10'd0), 32'h1234_5678);
    RST = 1'b0;

    // TRCD boundary: column command at ACT+4 dropped, ACT+5 accepted.
    act(11'h100);
    nops(3);
    rd_ignored(11'd0);
    rd(11'd0, 32'h1234_5678);

    // Byte-masked write then read-back.
    wr(11'd3, 4'b1100, 32'hAABB_CCDD);
    rd(11'd3, 32'h1122_CCDD);

    // Back-to-back reads return in issue order on consecutive cycles.
    rd(11'd0, 32'h1234_5678);
    rd(11'd1, 32'hA5A5_0001);
    rd(11'd2, 32'hDEAD_BEEF);

    // Read captures data at the command edge, before the following write lands.
    rd(11'd4, 32'h0BAD_F00D);
    wr(11'd4, 4'h0, 32'hFFFF_FFFF);
    rd(11'd4, 32'hFFFF_FFFF);

    // Ignored commands: deselected read, RAS+CAS together, ACT on open row, odd RAS WEn.
    drive(1'b1, 1'b1, 1'b0, 4'hF, 11'd0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 11'd5, 32'h0);
    act(11'h200);
    rd(11'd1, 32'hA5A5_0001);
    drive(1'b0, 1'b0, 1'b1, 4'h3, 11'd0, 32'h0);
    rd(11'd2, 32'hDEAD_BEEF);
    nops(CL + 1);
    check("mem_masked_write", peek(11'h100, 10'd3), 32'h1122_CCDD);
    check("mem_full_write", peek(11'h100, 10'd4), 32'hFFFF_FFFF);
    check("mem_illegal_no_write", peek(11'h100, 10'd5), 32'h5555_5555);

    // Closed row: reads dropped; a second PRE is harmless.
    pre();
    rd_ignored(11'd0);
    pre();
    nops(2);

    // Early column commands after ACT are dropped, then the row serves normally.
    act(11'h100);
    nops(1);
    rd_ignored(11'd0);
    wr(11'd5, 4'h0, 32'h0000_0000);
    nops(1);
    rd(11'd5, 32'h5555_5555);
    nops(CL + 1);

    // Reset with a read in flight: outputs clear at once and the read never returns.
    rd(11'd1, 32'hA5A5_0001);
    nops(1);
    @(posedge CK);
    @(posedge CK);
    #2;
    RST = 1'b1;
    sb.delete();
    last_q = '0;
    #1;
    check("async_reset_q", bus.Q, 32'h0);
    check("async_reset_valid", {31'b0, bus.VALID}, 32'h0);
    @(negedge CK);
    @(negedge CK);
    RST = 1'b0;
    nops(CL + 5);
    check("mem_after_reset_c0", peek(11'h100, 10'd0), 32'h1234_5678);
    check("mem_after_reset_c1", peek(11'h100, 10'd1), 32'hA5A5_0001);
    check("mem_after_reset_c3", peek(11'h100, 10'd3), 32'h1122_CCDD);

    // Reset closed the row.
    rd_ignored(11'd0);
    nops(CL + 3);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CK);
    if (sb.size() > 0) fail("drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
